ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 The block SHALL have parameter ITER, default 32, number of iteration cycles; it SHALL equal DATA_WIDTH.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port flush  input  1  kill any in-flight operation.
REQ-006 The block SHALL have port valid_i  input  1  RV32M operation present from the ID/EX register.
REQ-007 The block SHALL have port ins_func3_i  input  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 The block SHALL have port rd1_data_i  input  32  rs1 operand (multiplicand/dividend).
REQ-009 The block SHALL have port rd2_data_i  input  32  rs2 operand (multiplier/divisor).
REQ-010 The block SHALL have port rd_i  input  5  destination register index.
REQ-011 The block SHALL have port busy_o  output  1  stall request to the upstream pipeline.
REQ-012 The block SHALL have port done_o  output  1  single-cycle result-valid pulse.
REQ-013 The block SHALL have port result_o  output  32  operation result.
REQ-014 The block SHALL have port rd_o  output  5  destination index of the completed operation.

Function
REQ-015 The block SHALL have states IDLE, CALC, DONE, held in a registered state variable.
REQ-016 In IDLE, valid_i=1 with flush=0 SHALL capture operands, func3 and rd_i and enter CALC at that edge (cycle 0 = valid cycle).
REQ-017 CALC SHALL last exactly ITER cycles (cycles 1..32), processing one bit per cycle (shift-add multiply, restoring divide) on 32-bit magnitudes.
REQ-018 After the last CALC cycle the block SHALL enter DONE for exactly one cycle (cycle 33), then return to IDLE.
REQ-019 busy_o SHALL be 1 exactly when state is CALC; done_o SHALL be 1 exactly when state is DONE; both are register-driven, not combinational from inputs.
REQ-020 result_o and rd_o SHALL be updated at the edge entering DONE and SHALL hold their value until the next DONE entry or reset.
REQ-021 Signed ops SHALL compute on absolute values and apply the sign at completion: MULH signed x signed, MULHSU signed rs1 x unsigned rs2, MULHU unsigned x unsigned; MUL returns product[31:0], MULH* return product[63:32].
REQ-022 DIV/REM signs SHALL follow RISC-V: quotient negative iff operand signs differ, remainder takes the dividend sign.
REQ-023 Divisor 0 SHALL yield quotient 0xFFFFFFFF (DIV and DIVU) and remainder = dividend (REM and REMU), with normal 33-cycle latency.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL yield 0x80000000; the matching REM SHALL yield 0; latency unchanged.
REQ-025 valid_i SHALL be ignored in CALC and DONE; a new op SHALL be accepted only in IDLE.
REQ-026 flush=1 in any state SHALL force IDLE at the next edge; no done_o pulse SHALL follow; result_o/rd_o SHALL keep prior values.
REQ-027 flush=1 and valid_i=1 in the same IDLE cycle SHALL not accept the operation.
REQ-028 An op SHALL be accepted in the first IDLE cycle after DONE (back-to-back spacing 34 cycles).

Reset
REQ-029 rst_n=0 SHALL immediately, independent of clk, force state IDLE, busy_o=0, done_o=0, result_o=0, rd_o=0 and clear internal operand/accumulator registers.
REQ-030 After rst_n rises, the first rising edge SHALL behave as IDLE.

Verification
REQ-031 MUL 7 x 0xFFFFFFFD, rd 5 at cycle 0 -> busy_o cycles 1..32, done_o cycle 33 only, result_o 0xFFFFFFEB, rd_o 5.
REQ-032 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-033 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-034 DIVU 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; each at cycle 33.
REQ-035 flush at cycle 10 of a DIV -> busy_o 0 from cycle 11, no done_o, result_o unchanged; valid_i at cycle 11 accepted, done_o at cycle 44.
REQ-036 rst_n low mid-CALC (cycle 15, between edges) -> busy_o, done_o, result_o, rd_o 0 before next edge; no done_o after release.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand magnitudes,
// signs applied when the result is latched.
module ex_muldiv #(
   parameter int DATA_WIDTH = 32,
   parameter int ITER       = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  valid_i,
   input  logic [2:0]            ins_func3_i,
   input  logic [DATA_WIDTH-1:0] rd1_data_i,
   input  logic [DATA_WIDTH-1:0] rd2_data_i,
   input  logic [4:0]            rd_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic [4:0]            rd_o,
   output logic [1:0]            dbg_state
);

   // Handshake: an op is taken on any rising edge where state is IDLE,
   // valid_i=1 and flush=0; busy_o stalls upstream while CALC, and done_o
   // marks the single cycle in which result_o/rd_o hold the new value.

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(ITER + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [2:0]     op_q;
   logic [4:0]     rd_q;
   logic [W-1:0]   hi_q;
   logic [W-1:0]   lo_q;
   logic [W-1:0]   opb_q;
   logic [W-1:0]   dividend_q;
   logic           neg_q;
   logic           rem_neg_q;
   logic           div_zero_q;

   logic           a_signed;
   logic           b_signed;
   logic           a_neg;
   logic           b_neg;
   logic [W-1:0]   a_mag;
   logic [W-1:0]   b_mag;

   logic [W:0]     mul_sum;
   logic [W:0]     div_r;
   logic [W-1:0]   div_diff;
   logic           div_ge;
   logic [W-1:0]   hi_nx;
   logic [W-1:0]   lo_nx;
   logic [2*W-1:0] prod;
   logic [2*W-1:0] prod_s;
   logic [W-1:0]   quo;
   logic [W-1:0]   rem;
   logic [W-1:0]   res_nx;

   assign dbg_state = state;

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (ins_func3_i)
         3'd0, 3'd1, 3'd4, 3'd6: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         3'd2:    a_signed = 1'b1;
         default: ;
      endcase
   end

   assign a_neg = a_signed & rd1_data_i[W-1];
   assign b_neg = b_signed & rd2_data_i[W-1];
   assign a_mag = a_neg ? -rd1_data_i : rd1_data_i;
   assign b_mag = b_neg ? -rd2_data_i : rd2_data_i;

   // Multiply: {hi,lo} is the partial product with the multiplier shifting out of lo.
   // Divide: hi is the running remainder, lo shifts dividend out and quotient in.
   assign mul_sum  = {1'b0, hi_q} + {1'b0, opb_q & {W{lo_q[0]}}};
   assign div_r    = {hi_q, lo_q[W-1]};
   assign div_ge   = (div_r >= {1'b0, opb_q});
   assign div_diff = div_r[W-1:0] - opb_q;

   always_comb begin
      hi_nx = '0;
      lo_nx = '0;
      if (op_q[2]) begin
         hi_nx = div_ge ? div_diff : div_r[W-1:0];
         lo_nx = {lo_q[W-2:0], div_ge};
      end else begin
         hi_nx = mul_sum[W:1];
         lo_nx = {mul_sum[0], lo_q[W-1:1]};
      end
   end

   assign prod   = {hi_nx, lo_nx};
   assign prod_s = neg_q ? -prod : prod;
   assign quo    = neg_q ? -lo_nx : lo_nx;
   assign rem    = rem_neg_q ? -hi_nx : hi_nx;

   // Division by zero bypasses the sign fix-up: all-ones quotient, raw dividend remainder.
   always_comb begin
      res_nx = '0;
      case (op_q)
         3'd0:             res_nx = prod_s[W-1:0];
         3'd1, 3'd2, 3'd3: res_nx = prod_s[2*W-1:W];
         3'd4, 3'd5:       res_nx = div_zero_q ? {W{1'b1}} : quo;
         default:          res_nx = div_zero_q ? dividend_q : rem;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         op_q       <= '0;
         rd_q       <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         opb_q      <= '0;
         dividend_q <= '0;
         neg_q      <= 1'b0;
         rem_neg_q  <= 1'b0;
         div_zero_q <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         result_o   <= '0;
         rd_o       <= '0;
      end else if (flush) begin
         state  <= S_IDLE;
         busy_o <= 1'b0;
         done_o <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (valid_i) begin
                  state      <= S_CALC;
                  busy_o     <= 1'b1;
                  cnt        <= '0;
                  op_q       <= ins_func3_i;
                  rd_q       <= rd_i;
                  hi_q       <= '0;
                  lo_q       <= ins_func3_i[2] ? a_mag : b_mag;
                  opb_q      <= ins_func3_i[2] ? b_mag : a_mag;
                  neg_q      <= a_neg ^ b_neg;
                  rem_neg_q  <= a_neg;
                  div_zero_q <= (rd2_data_i == '0);
                  dividend_q <= rd1_data_i;
               end
            end
            S_CALC: begin
               hi_q <= hi_nx;
               lo_q <= lo_nx;
               cnt  <= cnt + CW'(1);
               if (cnt == CW'(ITER - 1)) begin
                  state    <= S_DONE;
                  busy_o   <= 1'b0;
                  done_o   <= 1'b1;
                  result_o <= res_nx;
                  rd_o     <= rd_q;
               end
            end
            S_DONE: begin
               state  <= S_IDLE;
               done_o <= 1'b0;
            end
            default: begin
               state  <= S_IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed vector table, randomized ops against an arithmetic
// reference, plus flush and asynchronous-reset sequences.
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        valid_i;
   logic [2:0]  ins_func3_i;
   logic [31:0] rd1_data_i;
   logic [31:0] rd2_data_i;
   logic [4:0]  rd_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;
   logic [31:0] last_exp = '0;
   logic [4:0]  last_rd  = '0;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[16];

   always #5 clk = ~clk;

   ex_muldiv #(.DATA_WIDTH(32), .ITER(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .valid_i     (valid_i),
      .ins_func3_i (ins_func3_i),
      .rd1_data_i  (rd1_data_i),
      .rd2_data_i  (rd2_data_i),
      .rd_i        (rd_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .result_o    (result_o),
      .rd_o        (rd_o),
      .dbg_state   (dbg_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: RV32M semantics from plain 64-bit arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint          zb = longint'({32'd0, b});
      longint unsigned ua = {32'd0, a};
      longint unsigned ub = {32'd0, b};
      longint          p;
      longint unsigned pu;
      logic [31:0]     r;
      r = '0;
      case (f)
         3'd0: begin p = sa * sb; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * zb; r = p[63:32]; end
         3'd3: begin pu = ua * ub; r = pu[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else begin p = sa / sb; r = p[31:0]; end
         end
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else begin p = sa % sb; r = p[31:0]; end
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Called one cycle-phase after a rising edge with the DUT idle (cycle 0).
   // valid_i stays high with junk operands through CALC to show it is ignored.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp);
      logic busy_ok;
      valid_i     = 1'b1;
      ins_func3_i = f;
      rd1_data_i  = a;
      rd2_data_i  = b;
      rd_i        = rd;
      step();
      busy_ok = 1'b1;
      for (int c = 1; c <= 32; c++) begin
         if (busy_o !== 1'b1 || done_o !== 1'b0) busy_ok = 1'b0;
         ins_func3_i = 3'($urandom);
         rd1_data_i  = $urandom;
         rd2_data_i  = $urandom;
         rd_i        = 5'($urandom);
         step();
      end
      check("busy_window", {31'd0, busy_ok}, 32'd1);
      check("done_at_33", {31'd0, done_o}, 32'd1);
      check("busy_at_33", {31'd0, busy_o}, 32'd0);
      check($sformatf("result f%0d %h,%h", f, a, b), result_o, exp);
      check("rd_o", {27'd0, rd_o}, {27'd0, rd});
      valid_i = 1'b0;
      step();
      check("idle_at_34", {30'd0, busy_o, done_o}, 32'd0);
      last_exp = exp;
      last_rd  = rd;
   endtask

   initial begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        quiet;
      int          sel;

      vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
      vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000};
      vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,          5'd4,  32'hFFFF_FFFD};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,          5'd6,  32'hFFFF_FFFF};
      vecs[6]  = '{3'd5, 32'd100,        32'd7,          5'd7,  32'd14};
      vecs[7]  = '{3'd7, 32'd100,        32'd7,          5'd8,  32'd2};
      vecs[8]  = '{3'd5, 32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF};
      vecs[9]  = '{3'd6, 32'd5,          32'd0,          5'd10, 32'd5};
      vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000};
      vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0};
      vecs[12] = '{3'd4, 32'hFFFF_FFF9, 32'd0,          5'd13, 32'hFFFF_FFFF};
      vecs[13] = '{3'd7, 32'h8000_0000, 32'd0,          5'd14, 32'h8000_0000};
      vecs[14] = '{3'd6, 32'hFFFF_FFF9, 32'd0,          5'd15, 32'hFFFF_FFF9};
      vecs[15] = '{3'd1, 32'hFFFF_FFFF, 32'd1,          5'd31, 32'hFFFF_FFFF};

      // Clock/reset
      rst_n       = 1'b0;
      flush       = 1'b0;
      valid_i     = 1'b0;
      ins_func3_i = '0;
      rd1_data_i  = '0;
      rd2_data_i  = '0;
      rd_i        = '0;
      #12;
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_done", {31'd0, done_o}, 32'd0);
      check("rst_result", result_o, 32'd0);
      check("rst_rd", {27'd0, rd_o}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Directed table, issued back to back
      for (int i = 0; i < 16; i++)
         run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);

      // Randomized ops against the reference
      for (int i = 0; i < 40; i++) begin
         f   = 3'($urandom_range(0, 7));
         sel = $urandom_range(0, 9);
         a   = $urandom;
         b   = $urandom;
         if (sel == 0) b = '0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 2) begin
            a = $urandom_range(0, 40);
            b = $urandom_range(1, 9);
            if ($urandom_range(0, 1) == 1) a = -a;
            if ($urandom_range(0, 1) == 1) b = -b;
         end
         rd = 5'($urandom);
         run_op(f, a, b, rd, ref_model(f, a, b));
      end

      // Flush at cycle 10 of a DIV, then a new op at cycle 11
      valid_i     = 1'b1;
      ins_func3_i = 3'd4;
      rd1_data_i  = 32'd1000;
      rd2_data_i  = 32'd3;
      rd_i        = 5'd21;
      step();
      valid_i = 1'b0;
      for (int c = 1; c < 10; c++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_busy", {31'd0, busy_o}, 32'd0);
      check("flush_done", {31'd0, done_o}, 32'd0);
      check("flush_result_kept", result_o, last_exp);
      check("flush_rd_kept", {27'd0, rd_o}, {27'd0, last_rd});
      run_op(3'd5, 32'd1000, 32'd3, 5'd22, 32'd333);

      // flush together with valid in IDLE must not start an op
      valid_i     = 1'b1;
      flush       = 1'b1;
      ins_func3_i = 3'd0;
      rd1_data_i  = 32'd9;
      rd2_data_i  = 32'd9;
      rd_i        = 5'd7;
      step();
      valid_i = 1'b0;
      flush   = 1'b0;
      quiet   = 1'b1;
      for (int c = 0; c < 36; c++) begin
         if (busy_o !== 1'b0 || done_o !== 1'b0) quiet = 1'b0;
         step();
      end
      check("flush_valid_ignored", {31'd0, quiet}, 32'd1);
      check("flush_valid_result", result_o, last_exp);

      // Asynchronous reset between edges in cycle 15 of CALC
      valid_i     = 1'b1;
      ins_func3_i = 3'd0;
      rd1_data_i  = 32'd123;
      rd2_data_i  = 32'd456;
      rd_i        = 5'd17;
      step();
      valid_i = 1'b0;
      for (int c = 1; c < 15; c++) step();
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy_o}, 32'd0);
      check("arst_done", {31'd0, done_o}, 32'd0);
      check("arst_result", result_o, 32'd0);
      check("arst_rd", {27'd0, rd_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      quiet = 1'b1;
      for (int c = 0; c < 36; c++) begin
         if (busy_o !== 1'b0 || done_o !== 1'b0) quiet = 1'b0;
         step();
      end
      check("arst_no_done", {31'd0, quiet}, 32'd1);
      run_op(3'd0, 32'd123, 32'd456, 5'd17, 32'd56088);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
